// File: rtl/itch_axis_tx.sv
// ITCH 5.0 command-to-AXI-Stream serializer (A/E/X/D/U), 4 bytes per beat, stream byte 0 in lane 0.
// Latency: tvalid one cycle after the command handshake; one idle cycle between messages.
// Backpressure: beat held stable while tready=0; cmd_ready low for the whole message.
// Optional: ITCH_TX_LEN_PREFIX_EN prepends a 2-byte big-endian message length.
module itch_axis_tx #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [3:0]                        cmd_type,
   input  logic [15:0]                       cmd_locate,
   input  logic [15:0]                       cmd_tracking,
   input  logic [47:0]                       cmd_timestamp,
   input  logic [63:0]                       cmd_order_ref,
   input  logic                              cmd_side,
   input  logic [31:0]                       cmd_shares,
   input  logic [31:0]                       cmd_price,
   input  logic [63:0]                       cmd_new_order_ref,
   input  logic [63:0]                       cmd_misc_data,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                              m_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              err_bad_type,
   output logic [31:0]                       msg_count
);

`ifdef ITCH_TX_LEN_PREFIX_EN
   localparam logic [7:0] PFX_BYTES = 8'd2;
`else
   localparam logic [7:0] PFX_BYTES = 8'd0;
`endif
   // 40 bytes: longest message (36) plus prefix (2), rounded up to whole beats
   localparam int BUF_W = 320;

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [3:0]         beat_q, beat_d;
   logic [3:0]         last_q, last_d;
   logic [3:0]         lkeep_q, lkeep_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic               err_q;
   logic [31:0]        cnt_q;

   logic [287:0]       body;
   logic [BUF_W-1:0]   be;
   logic [7:0]         len, total, total_m1;
   logic               type_ok;
   logic               fire, beat_acc, last_beat;

   assign fire      = cmd_valid && (state_q == IDLE);
   assign last_beat = (state_q == SEND) && (beat_q == last_q);
   assign beat_acc  = (state_q == SEND) && m_axis_tready;

   // Assemble the big-endian message image from the live command fields, then byte-swap so stream byte k sits at bits [8k+:8]
   always_comb begin
      body    = '0;
      len     = 8'd0;
      type_ok = 1'b1;
      case (cmd_type)
         4'd1: begin
            body = {8'h41, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
                    (cmd_side ? 8'h42 : 8'h53), cmd_shares, cmd_misc_data, cmd_price};
            len  = 8'd36;
         end
         4'd2: begin
            body = {8'h45, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
                    cmd_shares, cmd_misc_data, 40'h0};
            len  = 8'd31;
         end
         4'd3: begin
            body = {8'h58, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
                    cmd_shares, 104'h0};
            len  = 8'd23;
         end
         4'd4: begin
            body = {8'h44, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref, 136'h0};
            len  = 8'd19;
         end
         4'd5: begin
            body = {8'h55, cmd_locate, cmd_tracking, cmd_timestamp, cmd_order_ref,
                    cmd_new_order_ref, cmd_shares, cmd_price, 8'h0};
            len  = 8'd35;
         end
         default: type_ok = 1'b0;
      endcase
`ifdef ITCH_TX_LEN_PREFIX_EN
      be = {8'h00, len, body, 16'h0};
`else
      be = {body, 32'h0};
`endif
      total    = len + PFX_BYTES;
      total_m1 = total - 8'd1;
      last_d   = total_m1[5:2];
      case (total[1:0])
         2'd1:    lkeep_d = 4'b0001;
         2'd2:    lkeep_d = 4'b0011;
         2'd3:    lkeep_d = 4'b0111;
         default: lkeep_d = 4'b1111;
      endcase
      for (int k = 0; k < BUF_W / 8; k++) begin
         buf_d[8*k +: 8] = be[BUF_W-1-8*k -: 8];
      end
   end

   // Next-state logic: start on a valid command, step beats on tready, return to IDLE after the tlast beat
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (fire && type_ok) begin
               state_d = SEND;
               beat_d  = 4'd0;
            end
         end
         SEND: begin
            if (beat_acc) begin
               if (last_beat) state_d = IDLE;
               else           beat_d  = beat_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and beat pointer; reset drops any message in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   // Snapshot the message image at the handshake so later command changes cannot leak in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q   <= '0;
         last_q  <= 4'd0;
         lkeep_q <= 4'd0;
      end else if (fire && type_ok) begin
         buf_q   <= buf_d;
         last_q  <= last_d;
         lkeep_q <= lkeep_d;
      end
   end

   // Bad-type pulse and completed-message counter (wraps naturally)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
         cnt_q <= 32'd0;
      end else begin
         err_q <= fire && !type_ok;
         if (beat_acc && last_beat) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign cmd_ready     = (state_q == IDLE) && !rst;
   assign m_axis_tvalid = (state_q == SEND);
   assign m_axis_tlast  = last_beat;
   assign m_axis_tdata  = (state_q == SEND) ? buf_q[{beat_q, 5'd0} +: 32] : 32'h0;
   assign m_axis_tkeep  = (state_q != SEND) ? 4'b0000 : (last_beat ? lkeep_q : 4'b1111);
   assign m_axis_tstrb  = m_axis_tkeep;
   assign err_bad_type  = err_q;
   assign msg_count     = cnt_q;

endmodule
